// File: rtl/addsub_op_sequencer.sv
// Front-end sequencer for a combinational W-bit adder-subtractor: accepts a request,
// holds operands for SETTLE cycles, captures sum/carry and returns flagged results.
module addsub_op_sequencer #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  input  logic         in_acc,
  output logic [W-1:0] as_a,
  output logic [W-1:0] as_b,
  output logic         as_cin,
  input  logic [W-1:0] as_sum,
  input  logic         as_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         out_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t         state_r;
  state_t         state_nxt_s;
  logic [3:0]     cnt_r;
  logic [W-1:0]   as_a_r;
  logic [W-1:0]   as_b_r;
  logic           as_cin_r;
  logic [W-1:0]   acc_r;
  logic           out_valid_r;
  logic [W-1:0]   out_result_r;
  logic           out_cout_r;
  logic           out_ovf_r;
  logic           out_zero_r;
  logic           in_ready_s;
  logic           accept_s;
  logic           capture_s;
  logic           retire_s;

  // Signed overflow: operands (after subtract inversion) agree in sign, sum does not.
  function automatic logic ovf_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] sum, input logic sub);
    logic [W-1:0] b_eff;
    b_eff = sub ? ~b : b;
    return (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
  endfunction

  assign in_ready   = in_ready_s;
  assign as_a       = as_a_r;
  assign as_b       = as_b_r;
  assign as_cin     = as_cin_r;
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_cout   = out_cout_r;
  assign out_ovf    = out_ovf_r;
  assign out_zero   = out_zero_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and handshake strobes; DONE can retire and accept on one edge.
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    retire_s    = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == 4'd0) begin
          capture_s   = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = EXEC;
        end
      end
      DONE: begin
        in_ready_s = out_ready;
        if (out_ready) begin
          retire_s = 1'b1;
          if (in_valid) begin
            accept_s    = 1'b1;
            state_nxt_s = EXEC;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operand registers and settle counter; operands are sampled only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      as_a_r   <= {W{1'b0}};
      as_b_r   <= {W{1'b0}};
      as_cin_r <= 1'b0;
      cnt_r    <= 4'd0;
    end else if (accept_s) begin
      as_a_r   <= in_acc ? acc_r : in_a;
      as_b_r   <= in_b;
      as_cin_r <= in_sub;
      cnt_r    <= SETTLE_M1;
    end else if ((state_r == EXEC) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Result capture, accumulator update and output-valid tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r        <= {W{1'b0}};
      out_valid_r  <= 1'b0;
      out_result_r <= {W{1'b0}};
      out_cout_r   <= 1'b0;
      out_ovf_r    <= 1'b0;
      out_zero_r   <= 1'b1;
    end else if (capture_s) begin
      acc_r        <= as_sum;
      out_valid_r  <= 1'b1;
      out_result_r <= as_sum;
      out_cout_r   <= as_cout;
      out_ovf_r    <= ovf_f(as_a_r, as_b_r, as_sum, as_cin_r);
      out_zero_r   <= (as_sum == {W{1'b0}});
    end else if (retire_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule
